regfile_wb_arbiter: RTL

- Shares the single register-file write port (RegWre/WriteReg/WriteData) between two write-back requesters: ALU result (ALU) and memory load (MEM).
- Each requester has a one-entry holding slot and a valid/ready handshake.
- Arbitration is fixed-priority with an anti-starvation counter and same-register age ordering.
- Exports a pending-write mask for hazard/stall logic in the multi-cycle controller.

---
 rtl/regfile_wb_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter sharing one register-file write port between an ALU and a MEM requester.
// Each source has a one-entry slot; fixed MEM priority with ALU anti-starvation and same-register age order.
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              RegWre,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              grant_src,
  output logic [31:0]       pending,
  output logic              idle
);

  localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

  logic              alu_full_q, alu_full_d;
  logic [ADDR_W-1:0] alu_reg_q, alu_reg_d;
  logic [DATA_W-1:0] alu_data_q, alu_data_d;
  logic              mem_full_q, mem_full_d;
  logic [ADDR_W-1:0] mem_reg_q, mem_reg_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              alu_older_q, alu_older_d;
  logic [3:0]        starve_q, starve_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              src_q, src_d;

  logic alu_gnt_s, mem_gnt_s, alu_acc_s, mem_acc_s;

  function automatic logic [31:0] onehot(input logic [ADDR_W-1:0] r);
    onehot = 32'd1 << r;
  endfunction

  // Arbitration among full slots
  always_comb begin
    alu_gnt_s = 1'b0;
    mem_gnt_s = 1'b0;
    if (alu_full_q && mem_full_q) begin
      if (alu_reg_q == mem_reg_q) begin
        if (alu_older_q) alu_gnt_s = 1'b1;
        else             mem_gnt_s = 1'b1;
      end else if (starve_q == LIMIT_C) begin
        alu_gnt_s = 1'b1;
      end else begin
        mem_gnt_s = 1'b1;
      end
    end else if (alu_full_q) begin
      alu_gnt_s = 1'b1;
    end else if (mem_full_q) begin
      mem_gnt_s = 1'b1;
    end else begin
      alu_gnt_s = 1'b0;
    end
  end

  assign alu_ready = !RST && (!alu_full_q || alu_gnt_s);
  assign mem_ready = !RST && (!mem_full_q || mem_gnt_s);
  // Writes to register 0 are swallowed by the handshake without touching a slot
  assign alu_acc_s = alu_valid && alu_ready && (alu_reg != {ADDR_W{1'b0}});
  assign mem_acc_s = mem_valid && mem_ready && (mem_reg != {ADDR_W{1'b0}});

  // Slot, age, starvation and output-stage next state
  always_comb begin
    alu_full_d  = alu_full_q && !alu_gnt_s;
    alu_reg_d   = alu_reg_q;
    alu_data_d  = alu_data_q;
    mem_full_d  = mem_full_q && !mem_gnt_s;
    mem_reg_d   = mem_reg_q;
    mem_data_d  = mem_data_q;
    alu_older_d = alu_older_q;
    starve_d    = 4'd0;
    we_d        = 1'b0;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    src_d       = src_q;
    if (alu_acc_s) begin
      alu_full_d = 1'b1;
      alu_reg_d  = alu_reg;
      alu_data_d = alu_data;
    end else begin
      alu_reg_d  = alu_reg_q;
    end
    if (mem_acc_s) begin
      mem_full_d = 1'b1;
      mem_reg_d  = mem_reg;
      mem_data_d = mem_data;
    end else begin
      mem_reg_d  = mem_reg_q;
    end
    // A freshly loaded ALU entry is never older; same-edge loads leave MEM older
    if (alu_acc_s) begin
      alu_older_d = 1'b0;
    end else if (mem_acc_s && alu_full_d) begin
      alu_older_d = 1'b1;
    end else begin
      alu_older_d = alu_older_q;
    end
    if (alu_full_q && !alu_gnt_s) begin
      starve_d = (starve_q >= LIMIT_C) ? LIMIT_C : starve_q + 4'd1;
    end else begin
      starve_d = 4'd0;
    end
    if (alu_gnt_s) begin
      we_d    = 1'b1;
      wreg_d  = alu_reg_q;
      wdata_d = alu_data_q;
      src_d   = 1'b0;
    end else if (mem_gnt_s) begin
      we_d    = 1'b1;
      wreg_d  = mem_reg_q;
      wdata_d = mem_data_q;
      src_d   = 1'b1;
    end else begin
      we_d    = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      alu_full_q  <= 1'b0;
      alu_reg_q   <= {ADDR_W{1'b0}};
      alu_data_q  <= {DATA_W{1'b0}};
      mem_full_q  <= 1'b0;
      mem_reg_q   <= {ADDR_W{1'b0}};
      mem_data_q  <= {DATA_W{1'b0}};
      alu_older_q <= 1'b0;
      starve_q    <= 4'd0;
      we_q        <= 1'b0;
      wreg_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      src_q       <= 1'b0;
    end else begin
      alu_full_q  <= alu_full_d;
      alu_reg_q   <= alu_reg_d;
      alu_data_q  <= alu_data_d;
      mem_full_q  <= mem_full_d;
      mem_reg_q   <= mem_reg_d;
      mem_data_q  <= mem_data_d;
      alu_older_q <= alu_older_d;
      starve_q    <= starve_d;
      we_q        <= we_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
      src_q       <= src_d;
    end
  end

  assign RegWre    = we_q;
  assign WriteReg  = wreg_q;
  assign WriteData = wdata_q;
  assign grant_src = src_q;
  assign pending   = (alu_full_q ? onehot(alu_reg_q) : 32'd0) |
                     (mem_full_q ? onehot(mem_reg_q) : 32'd0) |
                     (we_q       ? onehot(wreg_q)    : 32'd0);
  assign idle      = !alu_full_q && !mem_full_q && !we_q;

endmodule
